// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, skid-buffer occupancy states and the
// shifter status-flag bundle.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic l;
    } shift_flags_t;

endpackage

// File: rtl/shift_flag_gen.sv
// Combinational status flags for a left-shift result: zero, negative,
// carry (last bit shifted out) and lost-bits.
module shift_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]                 a,
    input  logic [SHW-1:0]                   shamt,
    input  logic [WIDTH-1:0]                 s,
    output logic [$bits(shift_flags_t)-1:0]  flags
);

    logic [WIDTH-1:0] lost_mask;
    logic [SHW-1:0]   c_idx;
    shift_flags_t     f;

    // Top shamt bits of A leave the word; an all-zero mask when shamt is 0.
    assign lost_mask = ~({WIDTH{1'b1}} >> shamt);
    // WIDTH - shamt, which wraps cleanly because WIDTH is a power of two.
    assign c_idx     = -shamt;

    always_comb begin
        f.z = (s == '0);
        f.n = s[WIDTH-1];
        f.l = |(a & lost_mask);
        f.c = (shamt != '0) ? a[c_idx] : 1'b0;
    end

    assign flags = f;

endmodule

// File: rtl/shift_result_stage.sv
// Registered output stage behind the left shifter with a 2-entry skid buffer.
// Define SHIFT_RESULT_FLAGS_EN to build Z/N/C/L flag generation and storage.
module shift_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [WIDTH-1:0] in_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_z,
    output logic             out_n,
    output logic             out_c,
    output logic             out_l
);

    occ_t             occ, occ_nxt;
    logic             acc, drn;
    logic             ld_main_in, ld_main_skid, ld_skid;
    logic [WIDTH-1:0] main_s, skid_s;

    // Ready comes from occupancy alone, so no combinational path from out_ready.
    assign in_ready  = (occ != FULL);
    assign out_valid = (occ != EMPTY);
    assign acc       = in_valid & in_ready;
    assign drn       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) occ <= EMPTY;
        else        occ <= occ_nxt;
    end

    always_comb begin
        occ_nxt      = occ;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (occ)
            EMPTY: begin
                if (acc) begin
                    occ_nxt    = ONE;
                    ld_main_in = 1'b1;
                end
            end
            ONE: begin
                if (acc && drn) begin
                    ld_main_in = 1'b1;
                end else if (drn) begin
                    occ_nxt = EMPTY;
                end else if (acc) begin
                    occ_nxt = FULL;
                    ld_skid = 1'b1;
                end
            end
            FULL: begin
                if (drn) begin
                    occ_nxt      = ONE;
                    ld_main_skid = 1'b1;
                end
            end
            default: occ_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_s <= '0;
            skid_s <= '0;
        end else begin
            if (ld_main_in)        main_s <= in_s;
            else if (ld_main_skid) main_s <= skid_s;
            if (ld_skid)           skid_s <= in_s;
        end
    end

    assign out_s = main_s;

`ifdef SHIFT_RESULT_FLAGS_EN
    shift_flags_t in_f, main_f, skid_f;

    shift_flag_gen #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_flag_gen (
        .a     (in_a),
        .shamt (in_shamt),
        .s     (in_s),
        .flags (in_f)
    );

    // Flags travel alongside their word through main/skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_f <= '0;
            skid_f <= '0;
        end else begin
            if (ld_main_in)        main_f <= in_f;
            else if (ld_main_skid) main_f <= skid_f;
            if (ld_skid)           skid_f <= in_f;
        end
    end

    assign out_z = main_f.z;
    assign out_n = main_f.n;
    assign out_c = main_f.c;
    assign out_l = main_f.l;
`else
    logic unused_in;
    assign unused_in = ^{in_a, in_shamt};

    assign out_z = 1'b0;
    assign out_n = 1'b0;
    assign out_c = 1'b0;
    assign out_l = 1'b0;
`endif

endmodule

// File: tb/tb_shift_result_stage.sv
// Scoreboard bench for shift_result_stage: directed flag cases, backpressure,
// streaming, random backpressure and mid-operation reset.
module tb_shift_result_stage;

`ifdef SHIFT_RESULT_FLAGS_EN
    localparam logic [3:0] FMASK = 4'hF;
`else
    localparam logic [3:0] FMASK = 4'h0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [4:0]  in_shamt;
    logic [31:0] in_s;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_s;
    logic        out_z, out_n, out_c, out_l;

    int          n_vec = 0;
    int          n_err = 0;
    bit          rand_rdy = 1'b0;
    logic [35:0] q[$];

    shift_result_stage #(.WIDTH(32), .SHW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_shamt  (in_shamt),
        .in_s      (in_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_z     (out_z),
        .out_n     (out_n),
        .out_c     (out_c),
        .out_l     (out_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: shift A into a double-width word; whatever lands above bit 31
    // was discarded, and its lowest bit is the last one shifted out.
    function automatic logic [35:0] expect_word(logic [31:0] a, logic [4:0] sh, logic [31:0] s);
        logic [63:0] w;
        logic [31:0] gone;
        logic [3:0]  f;
        w    = {32'b0, a} << sh;
        gone = w[63:32];
        f[3] = (s == 32'd0);
        f[2] = s[31];
        f[1] = (sh != 5'd0) ? gone[0] : 1'b0;
        f[0] = (gone != 32'd0);
        return {s, f & FMASK};
    endfunction

    function automatic logic [39:0] out_word();
        return {4'b0, out_s, out_z, out_n, out_c, out_l};
    endfunction

    // Monitor: pops and compares every word the DUT hands over.
    initial begin
        logic        stalled;
        logic [39:0] prev, cur;
        stalled = 1'b0;
        prev    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                cur = {3'b0, out_valid, out_s, out_z, out_n, out_c, out_l};
                if (stalled) chk("hold_stable", cur, prev);
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_word: got %h expected none at %0t", cur, $time);
                    end else begin
                        chk("data_order", out_word(), {4'b0, q.pop_front()});
                    end
                end
                stalled = out_valid && !out_ready;
                prev    = cur;
            end
        end
    end

    task automatic step(output logic acc);
        @(negedge clk);
        acc = in_valid && in_ready;
        #1;
        if (acc) q.push_back(expect_word(in_a, in_shamt, in_s));
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [31:0] a, input logic [4:0] sh, input logic [31:0] s);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_shamt = sh;
        in_s     = s;
        for (int i = 0; i < 200; i++) begin
            step(acc);
            if (acc) break;
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got no accept expected accept at %0t", $time);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic send_rand();
        logic [31:0] a;
        logic [4:0]  sh;
        a  = $urandom;
        sh = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 3) == 0) send(a, sh, $urandom);
        else                           send(a, sh, a << sh);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_shamt  = '0;
        in_s      = '0;
        out_ready = 1'b0;
        #3;
        chk("reset_valid", {39'b0, out_valid}, 40'd0);
        chk("reset_ready", {39'b0, in_ready}, 40'd1);
        chk("reset_word", out_word(), 40'd0);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Carry-out and lost bit
        out_ready = 1'b1;
        send(32'h8000_0001, 5'd1, 32'h0000_0002);
        chk("lat_valid", {39'b0, out_valid}, 40'd1);
        chk("carry_word", out_word(), {4'b0, 32'h0000_0002, 4'b0011 & FMASK});

        // Zero shift
        send(32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF);
        chk("zero_shift", out_word(), {4'b0, 32'hFFFF_FFFF, 4'b0100 & FMASK});

        // Maximum shift, then result shifted to zero
        send(32'h0000_0001, 5'd31, 32'h8000_0000);
        chk("max_shift", out_word(), {4'b0, 32'h8000_0000, 4'b0100 & FMASK});
        send(32'h0000_0002, 5'd31, 32'h0000_0000);
        chk("to_zero", out_word(), {4'b0, 32'h0000_0000, 4'b1011 & FMASK});
        idle(3);

        // Backpressure: third word must wait upstream
        out_ready = 1'b0;
        send(32'h0, 5'd0, 32'h1);
        send(32'h0, 5'd0, 32'h2);
        chk("full_ready", {39'b0, in_ready}, 40'd0);
        in_valid = 1'b1;
        in_a     = 32'h0;
        in_shamt = 5'd0;
        in_s     = 32'h3;
        for (int i = 0; i < 2; i++) begin
            step(acc);
            chk("held_upstream", {39'b0, acc}, 40'd0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(acc);
            if (acc) break;
        end
        chk("third_accept", {39'b0, acc}, 40'd1);
        in_valid = 1'b0;
        idle(4);
        chk("bp_drained", 40'(q.size()), 40'd0);

        // Streaming
        for (int i = 0; i < 100; i++) begin
            send_rand();
            chk("stream_valid", {39'b0, out_valid}, 40'd1);
        end
        idle(3);

        // Random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) send_rand();
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        idle(5);

        // Reset while FULL
        out_ready = 1'b0;
        send(32'h1234_5678, 5'd4, 32'h2345_6780);
        send(32'h0000_00FF, 5'd8, 32'h0000_FF00);
        chk("pre_reset_full", {39'b0, in_ready}, 40'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", {39'b0, out_valid}, 40'd0);
        chk("async_ready", {39'b0, in_ready}, 40'd1);
        chk("async_word", out_word(), 40'd0);
        q.delete();
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        send(32'h4000_0000, 5'd2, 32'h0000_0000);
        chk("post_reset_valid", {39'b0, out_valid}, 40'd1);
        chk("post_reset_word", out_word(), {4'b0, 32'h0, 4'b1011 & FMASK});
        idle(4);
        chk("final_empty", 40'(q.size()), 40'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_result_stage.md
# shift_result_stage

Registered output stage placed directly downstream of the 32-bit structural left shifter. It captures the shifter result together with the operands that produced it, derives status flags, and hands the word to the ALU result bus over a valid/ready handshake. A 2-entry skid buffer gives full throughput without a combinational ready path back into the shifter.

## Interface
- `WIDTH`, default 32: data width. Must equal the shifter width and be a power of two.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width (5 for 32).
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset. One clock; reset is asynchronous and active-low.
- `in_valid`  in  1: upstream word valid.
- `in_ready`  out  1: stage can accept a word.
- `in_a`  in  WIDTH: shifter operand A (unshifted).
- `in_shamt`  in  SHW: shift amount, the low SHW bits of operand B.
- `in_s`  in  WIDTH: shifter result S.
- `out_valid`  out  1: output word valid.
- `out_ready`  in  1: downstream accepts.
- `out_s`  out  WIDTH: registered result.
- `out_z`, `out_n`, `out_c`, `out_l`  out  1 each: zero, negative, carry (last bit shifted out), and lost-bits flags.

## Operation
- A transfer occurs on a rising edge when valid and ready are both high, on either side.
- Flags are computed from the input word at capture time:
  - Z = (in_s == 0).
  - N = in_s[WIDTH-1].
  - C = 0 if in_shamt == 0; otherwise C = in_a[WIDTH-in_shamt].
  - L = 0 if in_shamt == 0; otherwise L = OR of in_a[WIDTH-1 : WIDTH-in_shamt], i.e. any 1 bit discarded.
- The stage does not recheck in_s against in_a/in_shamt. The output is exactly what was presented.
- Buffer FSM, state register `occ`:
  - EMPTY: out_valid=0, in_ready=1. Accept moves to ONE, with the entry in the main register.
  - ONE: out_valid=1, in_ready=1.
    - Accept and drain together: stay in ONE, main register reloads.
    - Drain only: go to EMPTY.
    - Accept only: go to FULL, new word goes to the skid register.
  - FULL: out_valid=1, in_ready=0.
    - Drain: the skid entry moves to main, go to ONE.
    - Input is ignored while in_ready=0.
- Order is strictly FIFO. No word is dropped or duplicated.
- `in_ready` decodes from `occ` only and never depends on `out_ready` combinationally.

## Timing
- Latency: a word accepted at edge k is on `out_*` with out_valid=1 after edge k. It can be consumed at edge k+1.
- Throughput: 1 word/cycle sustained while out_ready=1.
- While out_valid=1 and out_ready=0, `out_s` and all flags hold stable.
- Reset values: occ=EMPTY, out_valid=0, in_ready=1, out_s=0, and all flags 0. Storage registers reset to 0.
- Reset asserted mid-operation discards all buffered words immediately, asynchronously. The first accept is possible at the first rising edge after rst_n rises.
- Shift amounts from 0 to WIDTH-1 are all legal, so there is no wrap case. in_shamt=0 is the only special case.

## Configuration
- `SHIFT_RESULT_FLAGS_EN` defined: Z/N/C/L are computed, stored per entry, and output as above.
- Not defined: no flag storage is built. `out_z`, `out_n`, `out_c`, `out_l` are tied to 0, and `in_a`/`in_shamt` are unused. Handshake and data behaviour are identical.

## Structure
- Shared package `alu_pkg` holds:
  - the `occ_t` enum (EMPTY, ONE, FULL),
  - the `shift_flags_t` packed struct {z, n, c, l},
  - the `ALU_WIDTH` = 32 constant.
- One sub-module, `shift_flag_gen`: combinational flag derivation from in_a/in_shamt/in_s, instantiated only under the macro.

## Test plan
- Flags from a carry-out: reset, then send in_a=0x8000_0001, in_shamt=1, in_s=0x0000_0002 with out_ready=1 → next cycle out_s=0x0000_0002, Z=0, N=0, C=1, L=1.
- Zero-shift special case: send in_a=0xFFFF_FFFF, in_shamt=0, in_s=0xFFFF_FFFF → N=1, C=0, L=0, Z=0.
- Result shifted to zero: send in_a=0x0000_0001, in_shamt=31, in_s=0x8000_0000, then in_a=0x0000_0002, in_shamt=31, in_s=0 → first word N=1, C=0, L=0. Second word Z=1, C=1, L=1.
- Backpressure: hold out_ready=0 and send 3 words (0x1, 0x2, 0x3) → in_ready drops after the 2nd accept and the 3rd word is held upstream. Raise out_ready → outputs 0x1, 0x2, 0x3 in order, one per cycle, none lost.
- Streaming: 100 back-to-back words with out_ready=1 → out_valid stays high continuously after the first cycle, and data matches input order.
- Reset mid-operation: assert rst_n=0 while in FULL → out_valid=0 and in_ready=1 immediately. After release, the next word passes with 1-cycle latency.
